// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes one RISC-V request at a time into ALU controls and returns the captured result and branch decision.
module alu_issue_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_opcode,
  input  logic [2:0] req_funct3,
  input  logic       req_funct7b5,
  input  logic [7:0] req_rs1,
  input  logic [7:0] req_rs2,
  input  logic [7:0] req_imm,
  output logic [1:0] alu_ctrl,
  output logic [7:0] alu_in_1,
  output logic [7:0] alu_in_2,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_taken,
  output logic       rsp_err,
  output logic [7:0] done_count
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;
  logic is_r, is_i, is_mem, is_b, is_and, is_or, dec_legal, dec_imm;
  logic [1:0] dec_ctrl;
  logic br_q, ne_q;
  always_comb begin
    is_r      = req_opcode == 7'b0110011;
    is_i      = req_opcode == 7'b0010011;
    is_mem    = (req_opcode == 7'b0000011) || (req_opcode == 7'b0100011);
    is_b      = req_opcode == 7'b1100011;
    is_and    = (is_r || is_i) && (req_funct3 == 3'b111);
    is_or     = (is_r || is_i) && (req_funct3 == 3'b110);
    dec_imm   = is_i || is_mem;
    dec_legal = is_and || is_or || is_mem || ((is_r || is_i) && (req_funct3 == 3'b000))
              || (is_b && (req_funct3[2:1] == 2'b00));
    dec_ctrl  = (is_b || (is_r && (req_funct3 == 3'b000) && req_funct7b5)) ? 2'd3 :
                is_and ? 2'd0 : is_or ? 2'd1 : 2'd2;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (req_valid ? (dec_legal ? EXEC : DONE) : IDLE) :
                (state == EXEC) ? DONE : (rsp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_ctrl   <= '0;
      alu_in_1   <= '0;
      alu_in_2   <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_err    <= 1'b0;
      done_count <= '0;
      br_q       <= 1'b0;
      ne_q       <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      if (dec_legal) begin
        alu_ctrl <= dec_ctrl;
        alu_in_1 <= req_rs1;
        alu_in_2 <= dec_imm ? req_imm : req_rs2;
        br_q     <= is_b;
        ne_q     <= req_funct3[0];
      end else begin
        rsp_err    <= 1'b1;
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
        rsp_taken  <= 1'b0;
      end
    end else if (state == EXEC) begin
      rsp_result <= alu_out;
      rsp_zero   <= alu_zero;
      rsp_taken  <= br_q && (alu_zero ^ ne_q);
      rsp_err    <= 1'b0;
    end else if (state == DONE && rsp_ready) begin
      done_count <= done_count + 8'd1;
    end
  end
endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front end that drives the 8-bit ALU: it accepts one decoded-instruction request at a time over a valid/ready handshake and translates opcode/funct fields into the ALU's 2-bit `ctrl` code. It presents registered operands to the ALU, captures the ALU result and zero flag, and returns the result with a branch decision over a second valid/ready handshake. It sits between the register-read stage and writeback/branch logic of the 8-bit RISC-V datapath.

## Interface
- No parameters; datapath width fixed at 8 bits, ALU ctrl width fixed at 2 bits.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_opcode` input 7: RISC-V opcode field.
- `req_funct3` input 3: funct3 field.
- `req_funct7b5` input 1: instruction bit 30.
- `req_rs1` input 8: rs1 operand value.
- `req_rs2` input 8: rs2 operand value.
- `req_imm` input 8: sign-truncated immediate.
- `alu_ctrl` output 2: to ALU `ctrl` (0 AND, 1 OR, 2 ADD, 3 SUB).
- `alu_in_1` output 8: to ALU `in_1`.
- `alu_in_2` output 8: to ALU `in_2`.
- `alu_out` input 8: from ALU `out`.
- `alu_zero` input 1: from ALU `zero`.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts response.
- `rsp_result` output 8: captured ALU result.
- `rsp_zero` output 1: captured zero flag.
- `rsp_taken` output 1: branch taken (branch opcodes only, else 0).
- `rsp_err` output 1: illegal/unsupported encoding.
- `done_count` output 8: count of completed responses, wraps 255->0.

## Operation
- Decode (on acceptance):
  - 0110011 R-type: f3=000, b5=0 -> ADD; f3=000, b5=1 -> SUB; f3=111 -> AND; f3=110 -> OR; in_2=rs2.
  - 0010011 I-type: f3=000 -> ADD; 111 -> AND; 110 -> OR; in_2=imm; b5 ignored.
  - 0000011 load / 0100011 store: ADD, in_2=imm (address).
  - 1100011 branch: SUB, in_2=rs2; f3=000 BEQ taken=zero; f3=001 BNE taken=!zero.
  - Any other opcode/funct3: illegal.
- in_1 = rs1 for all legal ops.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: req_ready=1. On req_valid: legal -> load alu_ctrl/alu_in_1/alu_in_2, go EXEC. Illegal -> rsp_err=1, rsp_result=0, rsp_zero=0, rsp_taken=0, go DONE (ALU outputs unchanged).
  - EXEC: req_ready=0; end of cycle capture alu_out->rsp_result, alu_zero->rsp_zero, compute rsp_taken, rsp_err=0; go DONE.
  - DONE: rsp_valid=1, response fields stable. On rsp_ready: done_count+1, go IDLE. Else hold.
- Arithmetic mod 256 (ALU wraps); no overflow flag.
- alu_* outputs hold last issued values in IDLE/DONE.

## Timing
- Reset values: req_ready=0 while reset asserted, then 1 (IDLE); rsp_valid=0; all other outputs 0; done_count=0.
- Legal request accepted at edge N -> ALU inputs valid cycle N+1 -> rsp_valid=1 from cycle N+2.
- Illegal request accepted at edge N -> rsp_valid=1 from cycle N+1.
- Response handshake at edge M -> rsp_valid=0, req_ready=1 in cycle M+1. No same-cycle accept in DONE; peak throughput one legal op per 3 cycles.
- req_valid ignored while not IDLE; requester holds request until req_ready.
- rsp_valid, once high, never drops without rsp_ready (except reset).
- Reset mid-operation (EXEC or DONE): pending response discarded, outputs to reset values asynchronously, done_count cleared.

## Test plan
- ADD R-type rs1=0x7F, rs2=0x01, f3=000, b5=0 -> alu_ctrl=2 at N+1; rsp_result=0x80, zero=0, err=0 at N+2.
- SUB wrap rs1=0x00, rs2=0x01, b5=1 -> rsp_result=0xFF; BEQ rs1=rs2=0x3C -> rsp_result=0, zero=1, taken=1; BNE same operands -> taken=0.
- ANDI rs1=0xF0, imm=0x3C -> ctrl=0, result 0x30; ORI same -> ctrl=1, result 0xFC; store rs1=0x10, imm=0x04 -> 0x14.
- Illegal opcode 0x7F -> rsp_valid at N+1, err=1, result=0, alu_* unchanged; R-type f3=001 -> err=1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0, new req_valid not accepted; 256 completed responses -> done_count returns to 0.
- Assert reset during EXEC -> rsp_valid stays 0, all outputs 0 immediately, next request after release completes normally.
